// File: rtl/hpdcache_req_sched.sv
// Round-robin scheduler sharing the HPDcache core request port between NumReq requesters.
// Caps in-flight requests per requester and issues uncached accesses alone on an idle cache.
module hpdcache_req_sched #(
    parameter int unsigned NumReq         = 3,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned MaxOutstanding = 7,
    parameter logic [63:0] CachedBase     = 64'h8000_0000,
    parameter logic [63:0] CachedLength   = 64'h4000_0000,
    localparam int unsigned SrcW          = $clog2(NumReq)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    input  logic [NumReq-1:0]           req_we_i,
    output logic                        mem_valid_o,
    input  logic                        mem_ready_i,
    output logic [AddrWidth-1:0]        mem_addr_o,
    output logic                        mem_we_o,
    output logic [SrcW-1:0]             mem_src_o,
    input  logic                        rsp_valid_i,
    input  logic [SrcW-1:0]             rsp_src_i,
    output logic                        busy_o,
    output logic                        err_o
);
    typedef enum logic [1:0] {ARB, UC_DRAIN, UC_WAIT} state_e;

    localparam logic [AddrWidth-1:0] BASE = AddrWidth'(CachedBase);
    localparam logic [AddrWidth-1:0] LEN  = AddrWidth'(CachedLength);
    localparam logic [3:0]           CAP  = 4'(MaxOutstanding);

    state_e          r_state;
    logic [3:0]      r_cnt [NumReq];
    logic [SrcW-1:0] r_rr_ptr;
    logic [SrcW-1:0] r_lock_src;
    logic [SrcW-1:0] r_uc_src;
    logic            r_lock;
    logic            r_err;
    logic            r_rst_q;

    logic [NumReq-1:0] w_elig;
    logic [NumReq-1:0] w_uc;
    logic [NumReq-1:0] w_inc;
    logic [NumReq-1:0] w_dec;
    logic              w_total_zero;
    logic              w_rr_found;
    logic              w_win_valid;
    logic              w_valid;
    logic              w_to_drain;
    logic              w_hs;
    logic [SrcW-1:0]   w_scan;
    logic [SrcW-1:0]   w_rr_idx;
    logic [SrcW-1:0]   w_win;

    always_comb begin
        w_total_zero = 1'b1;
        for (int unsigned i = 0; i < NumReq; i++) begin
            // Subtract-then-compare keeps the region check safe against base+length overflow
            w_uc[i]   = !((req_addr_i[i*AddrWidth +: AddrWidth] >= BASE) &&
                          ((req_addr_i[i*AddrWidth +: AddrWidth] - BASE) < LEN));
            w_elig[i] = req_valid_i[i] && (r_cnt[i] < CAP);
            if (r_cnt[i] != '0) w_total_zero = 1'b0;
        end

        w_rr_found = 1'b0;
        w_rr_idx   = r_rr_ptr;
        w_scan     = r_rr_ptr;
        for (int unsigned k = 0; k < NumReq; k++) begin
            w_scan = SrcW'((32'(r_rr_ptr) + k) % NumReq);
            if (!w_rr_found && w_elig[w_scan]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan;
            end
        end

        w_win       = r_lock ? r_lock_src : w_rr_idx;
        w_win_valid = r_lock ? w_elig[r_lock_src] : w_rr_found;
        w_valid     = 1'b0;
        w_to_drain  = 1'b0;
        case (r_state)
            ARB: begin
                if (w_win_valid) begin
                    if (w_uc[w_win] && !w_total_zero) w_to_drain = 1'b1;
                    else                              w_valid    = 1'b1;
                end
            end
            UC_DRAIN: begin
                w_win   = r_uc_src;
                w_valid = req_valid_i[r_uc_src] && w_total_zero;
            end
            default: ;
        endcase
    end

    assign mem_valid_o = w_valid && !rst_i && !r_rst_q;
    assign mem_src_o   = w_win;
    assign mem_addr_o  = req_addr_i[w_win*AddrWidth +: AddrWidth];
    assign mem_we_o    = req_we_i[w_win];
    assign w_hs        = mem_valid_o && mem_ready_i;
    assign busy_o      = !w_total_zero && !rst_i;
    assign err_o       = r_err && !rst_i;

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            w_inc[i]       = w_hs && (w_win == SrcW'(i));
            w_dec[i]       = rsp_valid_i && (rsp_src_i == SrcW'(i));
            req_ready_o[i] = w_inc[i];
        end
    end

    always_ff @(posedge clk_i) begin
        r_rst_q <= rst_i;
        if (rst_i) begin
            r_state    <= ARB;
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_src <= '0;
            r_uc_src   <= '0;
            r_err      <= 1'b0;
            for (int unsigned i = 0; i < NumReq; i++) r_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (w_dec[i] && (r_cnt[i] == '0)) r_err <= 1'b1;
                if (w_inc[i] && !w_dec[i])
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0))
                    r_cnt[i] <= r_cnt[i] - 4'd1;
            end

            r_lock     <= mem_valid_o && !mem_ready_i;
            r_lock_src <= w_win;
            if (w_hs)
                r_rr_ptr <= (w_win == SrcW'(NumReq-1)) ? '0 : w_win + SrcW'(1);

            case (r_state)
                ARB: begin
                    if (w_to_drain) begin
                        r_state  <= UC_DRAIN;
                        r_uc_src <= w_win;
                    end else if (w_hs && w_uc[w_win]) begin
                        r_state  <= UC_WAIT;
                        r_uc_src <= w_win;
                    end
                end
                UC_DRAIN: begin
                    if (w_hs)                            r_state <= UC_WAIT;
                    else if (!req_valid_i[r_uc_src])     r_state <= ARB;
                end
                UC_WAIT: begin
                    if (rsp_valid_i && (rsp_src_i == r_uc_src)) r_state <= ARB;
                end
                default: r_state <= ARB;
            endcase
        end
    end
endmodule
